tournament_resolver: RTL and testbench

Parametrised successor to the single-table meta chooser in the fetch/decode front end. It selects between local and global direction predictions through a saturating chooser table, then forms the fetch redirect with RAS > BTB > fall-through priority. Each IF prediction is queued in an in-flight FIFO until ID resolves it, so mispredict checking and chooser training use the original prediction record rather than ID_PC re-indexing. It adds stall handling, a configurable delay-slot mode, over/underflow flags and saturating statistics counters.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/meta_sat_table.sv | 33 +++
 rtl/tournament_resolver.sv | 133 +++++++++++++
 tb/tb_tournament_resolver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-prediction types: the in-flight prediction record and chooser helpers.
package bp_pkg;

  localparam int INSTR_BYTES  = 4;
  localparam int MAX_IDX_BITS = 16;

  // idx is sized for the widest supported table; narrower tables zero-extend.
  typedef struct packed {
    logic [MAX_IDX_BITS-1:0] idx;
    logic                    pred_l;
    logic                    pred_g;
    logic [31:0]             target;
  } inflight_t;

  // Weakly-local starting point: one below the midpoint of the counter range.
  function automatic int unsigned chooser_reset_val(int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/meta_sat_table.sv
// Chooser table: saturating counters, asynchronous read, single write port.
module meta_sat_table import bp_pkg::*; #(
  parameter int IDX_BITS = 10,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_up
);

  localparam int                  ENTRIES  = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(chooser_reset_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0] ctr [ENTRIES];

  // Same-cycle read of the entry being written sees the old value.
  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (wr_en) begin
      if (wr_up && ctr[wr_idx] != CTR_MAX)       ctr[wr_idx] <= ctr[wr_idx] + 1'b1;
      else if (!wr_up && ctr[wr_idx] != '0)      ctr[wr_idx] <= ctr[wr_idx] - 1'b1;
    end
  end

endmodule

// File: rtl/tournament_resolver.sv
// Tournament chooser plus redirect resolution; IF predictions wait in an in-flight
// FIFO so ID checks and trains against the original record.
module tournament_resolver import bp_pkg::*; #(
  parameter int IDX_BITS   = 10,
  parameter int CTR_BITS   = 2,
  parameter int DEPTH      = 7,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             IF_Valid,
  input  logic [31:0]      IF_PC,
  input  logic             Pred_L,
  input  logic             Pred_G,
  input  logic             Hit_BTB,
  input  logic [31:0]      Alt_PC_BTB,
  input  logic             Hit_RAS,
  input  logic [31:0]      Alt_PC_RAS,
  input  logic             ID_Valid,
  input  logic [31:0]      ID_PC,
  input  logic             Is_Branch,
  input  logic             Is_Taken,
  input  logic [31:0]      Alt_PC_ID,
  output logic             flush,
  output logic             request_alt_pc,
  output logic [31:0]      alt_address,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] branch_count,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int          PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          OCC_W     = $clog2(DEPTH + 1);
  localparam logic [31:0] STEP      = 32'(INSTR_BYTES);
  localparam logic [31:0] REDIR_OFS = 32'(INSTR_BYTES * (1 + DELAY_SLOT));

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  inflight_t        fifo [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [OCC_W-1:0] occ;

  logic [IDX_BITS-1:0] if_idx;
  logic [CTR_BITS-1:0] rd_ctr;
  logic                sel_pred, pred_take;
  logic [31:0]         target, correct, redir;
  inflight_t           head_rec, push_rec;
  logic                empty, full, have_head, mispred, pop, push_req, push, keep;
  logic                train_en;
  logic                unused_idx_hi;

  // ---- IF side: chooser select and predicted target
  assign if_idx    = IF_PC[IDX_BITS+1:2];
  assign sel_pred  = rd_ctr[CTR_BITS-1] ? Pred_G : Pred_L;
  assign pred_take = Hit_RAS | (Hit_BTB & sel_pred);
  assign target    = Hit_RAS ? Alt_PC_RAS : (pred_take ? Alt_PC_BTB : IF_PC + STEP);
  assign push_rec  = '{idx: MAX_IDX_BITS'(if_idx), pred_l: Pred_L, pred_g: Pred_G, target: target};

  // ---- ID side: compare against the oldest in-flight record
  assign empty     = (occ == '0);
  assign full      = (occ == OCC_W'(DEPTH));
  assign head_rec  = fifo[head];
  assign correct   = Is_Taken ? Alt_PC_ID : ID_PC + STEP;
  assign redir     = Is_Taken ? Alt_PC_ID : ID_PC + REDIR_OFS;
  assign have_head = ID_Valid & ~empty;
  assign mispred   = have_head & Is_Branch & (head_rec.target != correct);
  assign pop       = have_head & ~STALL;
  assign push_req  = IF_Valid & ~STALL & ~mispred;
  assign push      = push_req & (~full | pop);
  // On a flush only the delay-slot instruction (if fetched) survives.
  assign keep      = (DELAY_SLOT != 0) && (occ > OCC_W'(1));
  assign train_en  = pop & Is_Branch & (head_rec.pred_l != head_rec.pred_g);
  assign unused_idx_hi = ^head_rec.idx;

  meta_sat_table #(.IDX_BITS(IDX_BITS), .CTR_BITS(CTR_BITS)) u_chooser (
    .clk    (CLK),
    .rst_n  (RESET),
    .rd_idx (if_idx),
    .rd_ctr (rd_ctr),
    .wr_en  (train_en),
    .wr_idx (head_rec.idx[IDX_BITS-1:0]),
    .wr_up  (head_rec.pred_g == Is_Taken)
  );

  always_ff @(posedge CLK) begin
    if (push) fifo[tail] <= push_rec;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (!STALL) begin
      if (mispred) begin
        head <= ptr_inc(head);
        tail <= keep ? ptr_inc(ptr_inc(head)) : ptr_inc(head);
        occ  <= keep ? OCC_W'(1) : '0;
      end else begin
        if (push) tail <= ptr_inc(tail);
        if (pop)  head <= ptr_inc(head);
        if (push && !pop)      occ <= occ + 1'b1;
        else if (pop && !push) occ <= occ - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flush          <= 1'b0;
      request_alt_pc <= 1'b0;
      alt_address    <= '0;
      miss_count     <= '0;
      branch_count   <= '0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
    end else if (!STALL) begin
      flush          <= mispred;
      request_alt_pc <= mispred | pred_take;
      alt_address    <= mispred ? redir : target;
      if (mispred && miss_count != '1)            miss_count   <= miss_count + 1'b1;
      if (pop && Is_Branch && branch_count != '1) branch_count <= branch_count + 1'b1;
      if (ID_Valid && empty)                      err_underflow <= 1'b1;
      if (push_req && full && !pop)               err_overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tournament_resolver.sv
// Bench for tournament_resolver: directed scenarios then random traffic against a queue-based model.
module tb_tournament_resolver;

  localparam int IDX_BITS   = 10;
  localparam int CTR_BITS   = 2;
  localparam int DEPTH      = 7;
  localparam int DELAY_SLOT = 1;
  localparam int CNT_W      = 4;

  logic CLK = 1'b0, RESET = 1'b1, STALL = 1'b0;
  logic IF_Valid = 1'b0, Pred_L = 1'b0, Pred_G = 1'b0, Hit_BTB = 1'b0, Hit_RAS = 1'b0;
  logic ID_Valid = 1'b0, Is_Branch = 1'b0, Is_Taken = 1'b0;
  logic [31:0] IF_PC = '0, Alt_PC_BTB = '0, Alt_PC_RAS = '0, ID_PC = '0, Alt_PC_ID = '0;
  logic flush, request_alt_pc, err_overflow, err_underflow;
  logic [31:0] alt_address;
  logic [CNT_W-1:0] miss_count, branch_count;

  tournament_resolver #(
    .IDX_BITS(IDX_BITS), .CTR_BITS(CTR_BITS), .DEPTH(DEPTH),
    .DELAY_SLOT(DELAY_SLOT), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .IF_Valid(IF_Valid), .IF_PC(IF_PC), .Pred_L(Pred_L), .Pred_G(Pred_G),
    .Hit_BTB(Hit_BTB), .Alt_PC_BTB(Alt_PC_BTB), .Hit_RAS(Hit_RAS), .Alt_PC_RAS(Alt_PC_RAS),
    .ID_Valid(ID_Valid), .ID_PC(ID_PC), .Is_Branch(Is_Branch), .Is_Taken(Is_Taken),
    .Alt_PC_ID(Alt_PC_ID),
    .flush(flush), .request_alt_pc(request_alt_pc), .alt_address(alt_address),
    .miss_count(miss_count), .branch_count(branch_count),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 CLK = ~CLK;

  // ---- reference model
  typedef struct { int idx; bit l; bit g; logic [31:0] target; } rec_t;
  rec_t        q[$];
  int          chooser [1 << IDX_BITS];
  bit          m_flush, m_req, m_ovf, m_unf;
  logic [31:0] m_alt;
  int          m_miss, m_br;
  int          tests = 0, fails = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < (1 << IDX_BITS); i++) chooser[i] = (1 << (CTR_BITS - 1)) - 1;
    m_flush = 0; m_req = 0; m_alt = '0; m_miss = 0; m_br = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step();
    int idx, cmax;
    bit sel, take, mis;
    logic [31:0] tgt, correct;
    rec_t h;
    if (STALL) return;
    cmax = (1 << CNT_W) - 1;
    idx  = int'((IF_PC >> 2) & 32'((1 << IDX_BITS) - 1));
    sel  = (chooser[idx] >= (1 << (CTR_BITS - 1))) ? Pred_G : Pred_L;
    take = Hit_RAS || (Hit_BTB && sel);
    tgt  = Hit_RAS ? Alt_PC_RAS : (take ? Alt_PC_BTB : IF_PC + 32'd4);
    mis  = 0;
    if (ID_Valid) begin
      if (q.size() == 0) m_unf = 1;
      else begin
        h = q.pop_front();
        if (Is_Branch) begin
          if (m_br < cmax) m_br++;
          correct = Is_Taken ? Alt_PC_ID : ID_PC + 32'd4;
          mis = (h.target != correct);
          if (h.l != h.g) begin
            if (h.g == Is_Taken) begin
              if (chooser[h.idx] < (1 << CTR_BITS) - 1) chooser[h.idx]++;
            end else if (chooser[h.idx] > 0) chooser[h.idx]--;
          end
        end
      end
    end
    if (mis) begin
      if (m_miss < cmax) m_miss++;
      while (q.size() > DELAY_SLOT) void'(q.pop_back());
    end else if (IF_Valid) begin
      if (q.size() < DEPTH) q.push_back('{idx, Pred_L, Pred_G, tgt});
      else m_ovf = 1;
    end
    m_flush = mis;
    m_req   = mis || take;
    m_alt   = mis ? (Is_Taken ? Alt_PC_ID : ID_PC + 32'(4 + 4 * DELAY_SLOT)) : tgt;
  endtask

  task automatic check_all(string t);
    chk({t, ".flush"}, flush, m_flush);
    chk({t, ".req"}, request_alt_pc, m_req);
    chk({t, ".alt"}, alt_address, m_alt);
    chk({t, ".miss"}, miss_count, m_miss);
    chk({t, ".br"}, branch_count, m_br);
    chk({t, ".ovf"}, err_overflow, m_ovf);
    chk({t, ".unf"}, err_underflow, m_unf);
  endtask

  task automatic step(string t);
    model_step();
    @(posedge CLK); #1;
    check_all(t);
  endtask

  task automatic set_if(bit v, logic [31:0] pc, bit l, bit g, bit btb, logic [31:0] bpc,
                        bit ras, logic [31:0] rpc);
    IF_Valid = v; IF_PC = pc; Pred_L = l; Pred_G = g;
    Hit_BTB = btb; Alt_PC_BTB = bpc; Hit_RAS = ras; Alt_PC_RAS = rpc;
  endtask

  task automatic set_id(bit v, logic [31:0] pc, bit br, bit tk, logic [31:0] apc);
    ID_Valid = v; ID_PC = pc; Is_Branch = br; Is_Taken = tk; Alt_PC_ID = apc;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #3 RESET = 1'b0;
    #1 model_reset();
    check_all("rst");
    @(negedge CLK); RESET = 1'b1;
  endtask

  task automatic rand_inputs();
    STALL      = ($urandom % 8) == 0;
    IF_Valid   = ($urandom % 4) != 0;
    IF_PC      = (($urandom % 2) != 0 ? 32'h1100 : 32'h100) + 32'(4 * ($urandom % 6));
    Pred_L     = 1'($urandom % 2);
    Pred_G     = 1'($urandom % 2);
    Hit_BTB    = 1'($urandom % 2);
    Alt_PC_BTB = 32'h200 + 32'(4 * ($urandom % 4));
    Hit_RAS    = ($urandom % 6) == 0;
    Alt_PC_RAS = 32'h3F0;
    ID_Valid   = 1'($urandom % 2);
    if (q.size() > 0 && ($urandom % 2) != 0) begin
      Is_Branch = 1'b1; Is_Taken = 1'b1; Alt_PC_ID = q[0].target; ID_PC = 32'h100;
    end else begin
      Is_Branch = ($urandom % 4) != 0;
      Is_Taken  = 1'($urandom % 2);
      ID_PC     = 32'h100 + 32'(4 * ($urandom % 6));
      Alt_PC_ID = 32'h200 + 32'(4 * ($urandom % 4));
    end
  endtask

  initial begin
    model_reset();
    #2 RESET = 1'b0;
    #1 check_all("reset");
    @(negedge CLK); RESET = 1'b1;

    // Weak-local chooser picks Pred_L=1 -> BTB target.
    set_if(1, 32'h100, 1, 0, 1, 32'h200, 0, 0); set_id(0, 0, 0, 0, 0);
    step("t1");
    chk("t1.req_c", request_alt_pc, 1); chk("t1.alt_c", alt_address, 32'h200);
    set_if(1, 32'h104, 0, 0, 0, 0, 0, 0);
    step("t2");
    // Resolve not-taken: mispredict, redirect past the delay slot.
    set_if(0, 0, 0, 0, 0, 0, 0, 0); set_id(1, 32'h100, 1, 0, 0);
    step("t3");
    chk("t3.flush_c", flush, 1); chk("t3.alt_c", alt_address, 32'h108); chk("t3.miss_c", miss_count, 1);
    set_id(1, 32'h104, 0, 0, 0);
    step("t4");
    chk("t4.flush_c", flush, 0); chk("t4.unf_c", err_underflow, 0);
    // Chooser trained toward global: Pred_G=1 now wins.
    set_id(0, 0, 0, 0, 0); set_if(1, 32'h100, 0, 1, 1, 32'h200, 0, 0);
    step("t5");
    chk("t5.req_c", request_alt_pc, 1); chk("t5.alt_c", alt_address, 32'h200);
    set_if(0, 0, 0, 0, 0, 0, 0, 0); set_id(1, 32'h100, 1, 1, 32'h200);
    step("t6");
    chk("t6.flush_c", flush, 0); chk("t6.br_c", branch_count, 2);
    // RAS beats BTB.
    set_id(0, 0, 0, 0, 0); set_if(1, 32'h300, 1, 1, 1, 32'h500, 1, 32'h3F0);
    step("ras");
    chk("ras.alt_c", alt_address, 32'h3F0);
    do_reset();

    // Overflow on DEPTH+1 pushes.
    for (int i = 0; i <= DEPTH; i++) begin
      set_if(1, 32'h100 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
      step("ovf");
    end
    chk("ovf.flag_c", err_overflow, 1);
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_if(1, 32'h100 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
      step("fill");
    end
    set_id(1, 32'h100, 0, 0, 0);
    step("pp");
    chk("pp.ovf_c", err_overflow, 0);
    set_id(0, 0, 0, 0, 0);
    step("pp2");
    chk("pp2.ovf_c", err_overflow, 1);
    do_reset();

    // Underflow on empty pop.
    set_if(0, 0, 0, 0, 0, 0, 0, 0); set_id(1, 32'h100, 1, 1, 32'h999);
    step("unf");
    chk("unf.flag_c", err_underflow, 1); chk("unf.flush_c", flush, 0);
    do_reset();

    // Stall freezes everything even with a mispredicting pop present.
    set_id(0, 0, 0, 0, 0);
    set_if(1, 32'h100, 0, 0, 0, 0, 0, 0); step("s0");
    set_if(1, 32'h104, 0, 0, 0, 0, 0, 0); step("s1");
    STALL = 1'b1;
    set_if(1, 32'h300, 1, 1, 1, 32'h500, 1, 32'h3F0); set_id(1, 32'h100, 1, 1, 32'h777);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.alt_c", alt_address, 32'h108); chk("stall.flush_c", flush, 0);
    end
    STALL = 1'b0;
    set_if(0, 0, 0, 0, 0, 0, 0, 0); set_id(1, 32'h100, 0, 0, 0);
    step("sp0"); step("sp1");
    chk("sp1.unf_c", err_underflow, 0);
    step("sp2");
    chk("sp2.unf_c", err_underflow, 1);
    STALL = 1'b0;
    do_reset();

    // Random traffic with periodic mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step("rnd");
      if (n % 750 == 749) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
